// File: rtl/alu_cmd_sequencer.sv
// Command sequencer and checker for a registered ALU: issues one operation,
// waits the ALU latency, returns the captured result and keeps pass/fail stats.
module alu_cmd_sequencer #(
  parameter int NUMBITS = 8,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_opcode,
  input  logic [NUMBITS-1:0] cmd_a,
  input  logic [NUMBITS-1:0] cmd_b,
  input  logic               cmd_check,
  input  logic [NUMBITS-1:0] cmd_exp_result,
  input  logic [2:0]         cmd_exp_flags,
  input  logic [2:0]         cmd_flag_mask,
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [NUMBITS-1:0] rsp_result,
  output logic [2:0]         rsp_flags,
  output logic               rsp_mismatch,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   tests_total,
  output logic [CNT_W-1:0]   tests_failed
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         wait_q, wait_d;
  logic [NUMBITS-1:0] a_q, b_q, exp_res_q, rsp_res_q;
  logic [2:0]         op_q, exp_flags_q, mask_q, rsp_flags_q;
  logic               chk_q, rsp_mis_q;
  logic [CNT_W-1:0]   total_q, total_d, failed_q, failed_d;
  logic               accept, capture, rsp_hs;
  logic [2:0]         alu_flags;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic is_mismatch(input logic               chk,
                                       input logic [NUMBITS-1:0] res,
                                       input logic [NUMBITS-1:0] exp_res,
                                       input logic [2:0]         flags,
                                       input logic [2:0]         exp_flags,
                                       input logic [2:0]         mask);
    return chk & ((res != exp_res) | (|((flags ^ exp_flags) & mask)));
  endfunction

  assign alu_flags = {alu_carryout, alu_overflow, alu_zero};
  assign accept    = (state_q == S_IDLE) && cmd_valid;
  assign capture   = (state_q == S_WAIT) && (wait_q == 4'd0);
  assign rsp_hs    = (state_q == S_RESP) && rsp_ready;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        state_d = S_WAIT;
        wait_d  = 4'(ALU_LAT);
      end
      S_WAIT: if (wait_q == 4'd0) state_d = S_RESP;
              else                wait_d  = wait_q - 4'd1;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Clear has priority over a counting handshake in the same cycle.
  always_comb begin
    total_d  = total_q;
    failed_d = failed_q;
    if (clr_stats) begin
      total_d  = '0;
      failed_d = '0;
    end else if (rsp_hs && chk_q) begin
      total_d = sat_inc(total_q);
      if (rsp_mis_q) failed_d = sat_inc(failed_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      chk_q       <= 1'b0;
      exp_res_q   <= '0;
      exp_flags_q <= '0;
      mask_q      <= '0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
      rsp_mis_q   <= 1'b0;
      total_q     <= '0;
      failed_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      total_q  <= total_d;
      failed_q <= failed_d;
      if (accept) begin
        a_q         <= cmd_a;
        b_q         <= cmd_b;
        op_q        <= cmd_opcode;
        chk_q       <= cmd_check;
        exp_res_q   <= cmd_exp_result;
        exp_flags_q <= cmd_exp_flags;
        mask_q      <= cmd_flag_mask;
      end
      if (capture) begin
        rsp_res_q   <= alu_result;
        rsp_flags_q <= alu_flags;
        rsp_mis_q   <= is_mismatch(chk_q, alu_result, exp_res_q,
                                   alu_flags, exp_flags_q, mask_q);
      end
    end
  end

  // cmd_ready is held low while reset is asserted so every output reads 0.
  assign cmd_ready    = reset && (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_opcode   = op_q;
  assign rsp_result   = rsp_res_q;
  assign rsp_flags    = rsp_flags_q;
  assign rsp_mismatch = rsp_mis_q;
  assign tests_total  = total_q;
  assign tests_failed = failed_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed and random commands against a
// behavioural ALU plus a reference model of responses and counters.
module tb_alu_cmd_sequencer;
  localparam int NB  = 8;
  localparam int LAT = 1;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_check;
  logic [2:0]    cmd_opcode, cmd_exp_flags, cmd_flag_mask;
  logic [NB-1:0] cmd_a, cmd_b, cmd_exp_result;
  logic [NB-1:0] alu_a, alu_b, alu_result;
  logic [2:0]    alu_opcode;
  logic          alu_carryout, alu_overflow, alu_zero;
  logic          rsp_valid, rsp_ready, rsp_mismatch, clr_stats;
  logic [NB-1:0] rsp_result;
  logic [2:0]    rsp_flags;
  logic [CW-1:0] tests_total, tests_failed;

  int n_cmp = 0;
  int n_err = 0;
  int tot   = 0;
  int fl    = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.NUMBITS(NB), .ALU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_check(cmd_check),
    .cmd_exp_result(cmd_exp_result), .cmd_exp_flags(cmd_exp_flags),
    .cmd_flag_mask(cmd_flag_mask),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_mismatch(rsp_mismatch),
    .clr_stats(clr_stats), .tests_total(tests_total), .tests_failed(tests_failed)
  );

  // Returns {carryout, overflow, zero, result}.
  function automatic logic [10:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    logic c = 1'b0;
    logic v = 1'b0;
    logic [7:0] r;
    case (op)
      3'd0: begin r = 8'(ua + ub); c = (ua + ub) > 255; end
      3'd1: begin r = 8'(ua + ub); c = (ua + ub) > 255; v = (sa + sb > 127) || (sa + sb < -128); end
      3'd2: begin r = 8'(ua - ub); c = ua < ub; end
      3'd3: begin r = 8'(ua - ub); c = ua < ub; v = (sa - sb > 127) || (sa - sb < -128); end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = 8'(ua / 2);
    endcase
    return {c, v, (r == 8'd0), r};
  endfunction

  // Registered ALU with a single cycle of latency.
  always_ff @(posedge clk)
    {alu_carryout, alu_overflow, alu_zero, alu_result} <= alu_ref(alu_opcode, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_total"}, 32'(tests_total), 32'(tot));
    check({tag, "_failed"}, 32'(tests_failed), 32'(fl));
  endtask

  task automatic scramble_cmd();
    cmd_opcode     = 3'($urandom);
    cmd_a          = 8'($urandom);
    cmd_b          = 8'($urandom);
    cmd_check      = 1'($urandom);
    cmd_exp_result = 8'($urandom);
    cmd_exp_flags  = 3'($urandom);
    cmd_flag_mask  = 3'($urandom);
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic chk, input logic [7:0] er, input logic [2:0] ef,
                        input logic [2:0] mk, input int bp, input logic clr, input logic keep_valid);
    logic [10:0] m;
    logic [7:0]  r;
    logic [2:0]  f;
    logic        mis;
    int          k;
    m   = alu_ref(op, a, b);
    r   = m[7:0];
    f   = m[10:8];
    mis = chk && ((r != er) || (((f ^ ef) & mk) != 3'b000));
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_check = chk;
    cmd_exp_result = er; cmd_exp_flags = ef; cmd_flag_mask = mk;
    @(posedge clk); #1;
    if (!keep_valid) cmd_valid = 1'b0;
    scramble_cmd();
    check("alu_a", 32'(alu_a), 32'(a));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_opcode", 32'(alu_opcode), 32'(op));
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    check("rsp_valid_early", 32'(rsp_valid), 32'd0);
    repeat (LAT) begin
      @(posedge clk); #1;
      check("rsp_valid_early", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    check("rsp_valid_rise", 32'(rsp_valid), 32'd1);
    check("rsp_result", 32'(rsp_result), 32'(r));
    check("rsp_flags", 32'(rsp_flags), 32'(f));
    check("rsp_mismatch", 32'(rsp_mismatch), 32'(mis));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_result", 32'(rsp_result), 32'(r));
      check("bp_rsp_flags", 32'(rsp_flags), 32'(f));
      check("bp_rsp_mismatch", 32'(rsp_mismatch), 32'(mis));
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_alu_a", 32'(alu_a), 32'(a));
      if (keep_valid) scramble_cmd();
    end
    rsp_ready = 1'b1; clr_stats = clr;
    @(posedge clk); #1;
    rsp_ready = 1'b0; clr_stats = 1'b0;
    if (clr) begin
      tot = 0; fl = 0;
    end else if (chk) begin
      if (tot < 15) tot++;
      if (mis && fl < 15) fl++;
    end
    check("rsp_valid_fall", 32'(rsp_valid), 32'd0);
    check("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
    check("alu_a_hold", 32'(alu_a), 32'(a));
    check_counters("cnt");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] m;
    logic [2:0]  op;
    logic [7:0]  a, b, er;
    logic [2:0]  ef;
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; clr_stats = 1'b0;
    cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_check = 1'b0;
    cmd_exp_result = '0; cmd_exp_flags = '0; cmd_flag_mask = '0;
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check_counters("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    do_cmd(3'b000, 8'hFF, 8'h01, 1'b1, 8'h00, 3'b101, 3'b111, 0, 1'b0, 1'b0);
    check("uadd_result_const", 32'(rsp_result), 32'h00);
    check("uadd_flags_const", 32'(rsp_flags), 32'b101);
    do_cmd(3'b110, 8'h0F, 8'hF0, 1'b1, 8'h00, 3'b000, 3'b000, 0, 1'b0, 1'b0);
    check("xor_mismatch_const", 32'(rsp_mismatch), 32'd1);
    do_cmd(3'b111, 8'h1A, 8'h00, 1'b0, 8'h00, 3'b000, 3'b000, 0, 1'b0, 1'b0);
    check("div2_result_const", 32'(rsp_result), 32'h0D);
    repeat (4) begin
      @(posedge clk); #1;
      check("idle_alu_a_hold", 32'(alu_a), 32'h1A);
    end

    // Backpressure with cmd_valid held high throughout.
    do_cmd(3'b001, 8'h7F, 8'h01, 1'b1, 8'h80, 3'b010, 3'b111, 5, 1'b0, 1'b1);
    do_cmd(3'b010, 8'h05, 8'h07, 1'b1, 8'hFE, 3'b100, 3'b111, 0, 1'b0, 1'b0);

    // Reset during WAIT discards the command.
    cmd_valid = 1'b1; cmd_opcode = 3'b100; cmd_a = 8'h3C; cmd_b = 8'hFF; cmd_check = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("wrst_alu_a", 32'(alu_a), 32'd0);
    check("wrst_alu_b", 32'(alu_b), 32'd0);
    check("wrst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("wrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wrst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("wrst_rsp_mismatch", 32'(rsp_mismatch), 32'd0);
    tot = 0; fl = 0;
    check_counters("wrst");
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("wrst_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    rsp_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("wrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;
    check_counters("wrst_after");

    // Clear coinciding with a failing checked handshake.
    do_cmd(3'b101, 8'h11, 8'h22, 1'b1, 8'h33, 3'b000, 3'b111, 1, 1'b0, 1'b0);
    do_cmd(3'b110, 8'h0F, 8'hF0, 1'b1, 8'h00, 3'b000, 3'b000, 0, 1'b1, 1'b0);
    check("clr_total_zero", 32'(tests_total), 32'd0);

    // Saturation of both counters.
    for (int i = 0; i < 20; i++)
      do_cmd(3'b100, 8'(i), 8'hFF, 1'b1, 8'(i + 1), 3'b000, 3'b000, 0, 1'b0, 1'b0);
    check("sat_total", 32'(tests_total), 32'hF);
    check("sat_failed", 32'(tests_failed), 32'hF);

    // Standalone clear while idle.
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    tot = 0; fl = 0;
    check_counters("idle_clr");
    check("idle_clr_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      m  = alu_ref(op, a, b);
      er = ($urandom_range(0, 1) == 1) ? m[7:0] : 8'($urandom);
      ef = ($urandom_range(0, 1) == 1) ? m[10:8] : 3'($urandom);
      do_cmd(op, a, b, 1'($urandom), er, ef, 3'($urandom), int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
